mvm_stream_driver: RTL and testbench
====================================

# mvm_stream_driver

Streaming source/sink that drives the matrix-vector multiplier's input stream and collects its output stream. A host preloads matrix A (row-major) and vector B into local registers, pulses `start`, and the block serialises A then B one 8-bit element per handshake, then accepts `NROWS_A` 16-bit results into a readable result bank. It sits between the control/host logic and the multiplier and is the master for the multiplier's `s_valid/s_ready` port and the slave for its `m_valid/m_ready` port.

## Interface
- `NROWS_A`, 3, rows of A and number of results
- `NCOLS_A`, 3, columns of A; also the length of B
- `TIMEOUT`, 1024, stall limit in cycles; used only with `MVM_DRV_TIMEOUT_EN`
- `clk` in 1 — clock
- `reset` in 1 — synchronous, active-high; one clock; reset is synchronous and active-high
- `cfg_wr_en` in 1 — host write strobe for an operand element
- `cfg_addr` in `$clog2(NROWS_A*NCOLS_A+NCOLS_A)` — 0..NA-1 is A[k], NA..NA+NCOLS_A-1 is B[k], where NA=NROWS_A*NCOLS_A
- `cfg_data` in 8 signed — operand element
- `start` in 1 — single-cycle start pulse
- `busy` out 1 — high from SEND_A through COLLECT
- `done` out 1 — one-cycle pulse when the last result is captured
- `err` out 1 — sticky timeout flag; always 0 without the macro
- `out_data` out 8 signed — element to the multiplier's `data_in`
- `out_valid` out 1 — drives the multiplier's `s_valid`
- `out_ready` in 1 — from the multiplier's `s_ready`
- `in_data` in 16 signed — from the multiplier's `data_out`
- `in_valid` in 1 — from the multiplier's `m_valid`
- `in_ready` out 1 — drives the multiplier's `m_ready`
- `in_overflow` in 1 — from the multiplier's `overflow`
- `res_addr` in `$clog2(NROWS_A)` — result read index
- `res_data` out 16 signed — combinational read of result[`res_addr`]
- `ovf_flag` out 1 — sticky OR of `in_overflow`, sampled at each accepted result

## Operation
- States: IDLE, SEND_A, SEND_B, COLLECT.
- IDLE: `cfg_wr_en` writes `cfg_data` to the operand register at `cfg_addr`. Writes to out-of-range addresses are ignored. Writes are ignored in every other state.
- IDLE with `start`=1: clear `ovf_flag`, `err`, the element index and the result index, then go to SEND_A. `start` is ignored outside IDLE.
- SEND_A:
  - `out_valid`=1; `out_data`=A[idx].
  - A transfer is `out_valid && out_ready`; on each transfer idx increments.
  - The transfer at idx=NA-1 resets idx to 0 and moves to SEND_B.
- SEND_B: same as SEND_A using B[idx]. The transfer at idx=NCOLS_A-1 moves to COLLECT.
- COLLECT:
  - `in_ready`=1.
  - An accept is `in_valid && in_ready`. On each accept, store `in_data` into result[ridx], increment ridx, and set `ovf_flag` if `in_overflow` is high.
  - The accept at ridx=NROWS_A-1 pulses `done` for one cycle and returns to IDLE.
- `in_valid` outside COLLECT is not accepted (`in_ready`=0). The result bank and operand registers are not modified.
- Operands persist across runs; a second `start` without rewrites resends the same data.
- `res_data` is readable in any state; during a run it returns partial or old results.

## Timing
- Reset values:
  - state IDLE; `busy`=0, `done`=0, `err`=0, `out_valid`=0, `in_ready`=0, `ovf_flag`=0, idx=0, ridx=0.
  - `out_data` and `res_data` are 0, because operand and result registers clear on reset.
- `start` sampled at edge T gives `out_valid`=1 with `out_data`=A[0] in cycle T+1.
- Full throughput: with `out_ready` held high, A and B take NA+NCOLS_A consecutive cycles and no bubbles are inserted.
- While `out_valid`=1 and `out_ready`=0, `out_data` holds stable.
- The cycle after the last B transfer, `out_valid`=0 and `in_ready`=1.
- `done` is high in the cycle after the last accept edge, coincident with state=IDLE and `busy`=0.
- `busy`, `out_valid` and `in_ready` are decoded from registered state only and do not depend combinationally on `out_ready` or `in_valid`.
- Reset mid-run: the block returns to IDLE on the next edge and all registers take their reset values.

## Configuration
- `MVM_DRV_TIMEOUT_EN` defined:
  - A cycle counter runs in SEND_A, SEND_B and COLLECT and clears on every transfer or accept.
  - When it reaches `TIMEOUT`, set `err`, abort to IDLE, and do not pulse `done`.
- `MVM_DRV_TIMEOUT_EN` undefined: no counter, `err` is tied to 0, and the block waits indefinitely.

## Test plan
- Load A=[1,2,3,4,5,6,7,8,9] and B=[1,0,-1]; `start`; `out_ready`=1. Expect `out_data` sequence 1..9,1,0,-1 on 12 consecutive cycles starting at T+1.
- Toggle `out_ready` 1,0,0,1 repeatedly during SEND. Expect every element sent exactly once, in order, with `out_data` stable while stalled.
- In COLLECT, drive results -2, -2, -2 with gaps between them. Expect `res_data` at addresses 0,1,2 = -2,-2,-2, a single `done` pulse, and `busy`=0 after it.
- Assert `in_overflow` on the second accepted result. Expect `ovf_flag`=1 after it, and `ovf_flag` cleared by the next `start`.
- Pulse `start` and `cfg_wr_en` while in SEND_A. Expect no restart and no change to operands. Assert `reset` mid-SEND_B: expect IDLE and `out_valid`=0 on the next cycle.
- With `MVM_DRV_TIMEOUT_EN` and `TIMEOUT`=16, hold `out_ready`=0. Expect `err`=1 and state IDLE after 16 stalled cycles, and no `done` pulse.

Source files
------------

// File: rtl/mvm_stream_driver_if.sv
// Stream bundle between mvm_stream_driver and the matrix-vector multiplier.
// master = driver side (sources operands, sinks results); slave = multiplier side.
interface mvm_stream_driver_if;
  logic signed [7:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic               in_overflow;

  modport master (
    output out_data, out_valid, in_ready,
    input  out_ready, in_data, in_valid, in_overflow
  );

  modport slave (
    input  out_data, out_valid, in_ready,
    output out_ready, in_data, in_valid, in_overflow
  );
endinterface

// File: rtl/mvm_stream_driver.sv
// Serialises preloaded A (row-major) then B to the multiplier and collects NROWS_A results.
// Optional stall watchdog enabled by defining MVM_DRV_TIMEOUT_EN.
module mvm_stream_driver #(
  parameter int NROWS_A = 3,
  parameter int NCOLS_A = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          cfg_wr_en,
  input  logic [$clog2(NROWS_A*NCOLS_A+NCOLS_A)-1:0]    cfg_addr,
  input  logic signed [7:0]                             cfg_data,
  input  logic                                          start,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          err,
  mvm_stream_driver_if.master                           strm,
  input  logic [$clog2(NROWS_A)-1:0]                    res_addr,
  output logic signed [15:0]                            res_data,
  output logic                                          ovf_flag
);

  localparam int NA = NROWS_A * NCOLS_A;
  localparam int NT = NA + NCOLS_A;
  localparam int AW = $clog2(NT);
  localparam int RW = $clog2(NROWS_A);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SEND_A  = 2'd1;
  localparam logic [1:0] S_SEND_B  = 2'd2;
  localparam logic [1:0] S_COLLECT = 2'd3;

  localparam logic [AW-1:0] LAST_A = AW'(NA - 1);
  localparam logic [AW-1:0] LAST_B = AW'(NCOLS_A - 1);
  localparam logic [AW-1:0] B_BASE = AW'(NA);
  localparam logic [RW-1:0] LAST_R = RW'(NROWS_A - 1);

  logic [1:0]         state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [RW-1:0]      ridx_q, ridx_d;
  logic signed [7:0]  opr_q [NT];
  logic signed [7:0]  opr_d [NT];
  logic signed [15:0] res_q [NROWS_A];
  logic signed [15:0] res_d [NROWS_A];
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               xfer, acc;

`ifdef MVM_DRV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  assign err = err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign err = 1'b0;
`endif

  // Handshake-facing outputs come from registered state only.
  assign strm.out_valid = (state_q == S_SEND_A) || (state_q == S_SEND_B);
  assign strm.in_ready  = (state_q == S_COLLECT);
  assign strm.out_data  = (state_q == S_SEND_B) ? opr_q[B_BASE + idx_q] : opr_q[idx_q];

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign ovf_flag = ovf_q;
  assign res_data = (int'(res_addr) < NROWS_A) ? res_q[res_addr] : '0;

  assign xfer = strm.out_valid && strm.out_ready;
  assign acc  = strm.in_valid && strm.in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ridx_d  = ridx_q;
    opr_d   = opr_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
`ifdef MVM_DRV_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cfg_wr_en && (int'(cfg_addr) < NT)) opr_d[cfg_addr] = cfg_data;
        if (start) begin
          ovf_d   = 1'b0;
          idx_d   = '0;
          ridx_d  = '0;
          state_d = S_SEND_A;
`ifdef MVM_DRV_TIMEOUT_EN
          err_d   = 1'b0;
          cnt_d   = '0;
`endif
        end
      end
      S_SEND_A: begin
        if (xfer) begin
          if (idx_q == LAST_A) begin
            idx_d   = '0;
            state_d = S_SEND_B;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_SEND_B: begin
        if (xfer) begin
          if (idx_q == LAST_B) begin
            idx_d   = '0;
            state_d = S_COLLECT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        if (acc) begin
          res_d[ridx_q] = strm.in_data;
          ovf_d         = ovf_q | strm.in_overflow;
          if (ridx_q == LAST_R) begin
            ridx_d  = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ridx_d = ridx_q + 1'b1;
          end
        end
      end
    endcase
`ifdef MVM_DRV_TIMEOUT_EN
    // Watchdog counts only stalled active cycles; expiry overrides the state decision above.
    if (state_q != S_IDLE) begin
      if (xfer || acc) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        err_d   = 1'b1;
        idx_d   = '0;
        ridx_d  = '0;
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ridx_q  <= '0;
      opr_q   <= '{default: '0};
      res_q   <= '{default: '0};
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef MVM_DRV_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ridx_q  <= ridx_d;
      opr_q   <= opr_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
`ifdef MVM_DRV_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mvm_stream_driver.sv
// Scoreboard bench for mvm_stream_driver: expected stream elements are queued by the
// stimulus and popped by a negedge monitor on every out_valid/out_ready transfer.
module tb_mvm_stream_driver;
  localparam int NR = 3;
  localparam int NC = 3;
  localparam int NT = NR * NC + NC;

  logic               clk = 1'b0;
  logic               reset, cfg_wr_en, start;
  logic [3:0]         cfg_addr;
  logic signed [7:0]  cfg_data;
  logic               busy, done, err, ovf_flag;
  logic [1:0]         res_addr;
  logic signed [15:0] res_data;

  mvm_stream_driver_if sif();

  mvm_stream_driver #(.NROWS_A(NR), .NCOLS_A(NC), .TIMEOUT(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_wr_en(cfg_wr_en),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .strm     (sif),
    .res_addr (res_addr),
    .res_data (res_data),
    .ovf_flag (ovf_flag)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic signed [7:0] exp_out[$];
  logic signed [7:0] ops[NT];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pop on transfer, hold-stability while stalled, done pulse count.
  logic signed [7:0] prev_data = '0;
  logic              prev_stall = 1'b0;
  always @(negedge clk) begin
    if (prev_stall && sif.out_valid) check("stall_hold", int'(sif.out_data), int'(prev_data));
    if (sif.out_valid && sif.out_ready) begin
      if (exp_out.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_xfer: got %0d expected no transfer at %0t", sif.out_data, $time);
      end else begin
        check("out_data", int'(sif.out_data), int'(exp_out.pop_front()));
      end
    end
    prev_stall = sif.out_valid && !sif.out_ready && !reset;
    prev_data  = sif.out_data;
    if (done) done_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_op(input int a, input logic signed [7:0] d);
    cfg_wr_en = 1'b1;
    cfg_addr  = 4'(a);
    cfg_data  = d;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic push_seq(input int n);
    for (int i = 0; i < n; i++) exp_out.push_back(ops[i]);
  endtask

  // Overflow and garbage data are held during gaps: only accepted beats may count.
  task automatic send_res(input logic signed [15:0] v, input logic ov, input int gap);
    sif.in_valid    = 1'b1;
    sif.in_data     = v;
    sif.in_overflow = ov;
    tick();
    sif.in_valid    = 1'b0;
    sif.in_data     = 16'sh7fff;
    sif.in_overflow = 1'b1;
    repeat (gap) tick();
    sif.in_overflow = 1'b0;
  endtask

  task automatic wait_collect();
    for (int c = 0; c < 64 && !sif.in_ready; c++) tick();
    check("reach_collect", int'(sif.in_ready), 1);
  endtask

  task automatic check_results(input int r0, input int r1, input int r2);
    res_addr = 2'd0; #1 check("res0", int'(res_data), r0);
    res_addr = 2'd1; #1 check("res1", int'(res_data), r1);
    res_addr = 2'd2; #1 check("res2", int'(res_data), r2);
  endtask

  initial begin
    logic pat[4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    for (int i = 0; i < 9; i++) ops[i] = 8'(i + 1);
    ops[9] = 8'sd1; ops[10] = 8'sd0; ops[11] = -8'sd1;

    reset = 1'b1; cfg_wr_en = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0;
    res_addr = '0; sif.out_ready = 1'b0; sif.in_valid = 1'b0;
    sif.in_data = '0; sif.in_overflow = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_out_valid", int'(sif.out_valid), 0);
    check("rst_in_ready", int'(sif.in_ready), 0);
    check("rst_ovf", int'(ovf_flag), 0);
    check("rst_out_data", int'(sif.out_data), 0);
    check("rst_res_data", int'(res_data), 0);
    sif.in_valid = 1'b1;
    tick();
    check("idle_no_accept", int'(sif.in_ready), 0);
    sif.in_valid = 1'b0;

    for (int i = 0; i < NT; i++) write_op(i, ops[i]);
    write_op(12, 8'sd55);

    // Run 1: full throughput
    push_seq(NT);
    sif.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("r1_first_valid", int'(sif.out_valid), 1);
    check("r1_first_data", int'(sif.out_data), 1);
    check("r1_busy", int'(busy), 1);
    repeat (11) tick();
    check("r1_last_valid", int'(sif.out_valid), 1);
    check("r1_last_data", int'(sif.out_data), -1);
    tick();
    check("r1_post_valid", int'(sif.out_valid), 0);
    check("r1_post_in_ready", int'(sif.in_ready), 1);
    check("r1_queue_empty", exp_out.size(), 0);
    send_res(-16'sd2, 1'b0, 2);
    check("r1_ovf_after_first", int'(ovf_flag), 0);
    send_res(-16'sd2, 1'b1, 1);
    check("r1_ovf_after_second", int'(ovf_flag), 1);
    send_res(-16'sd2, 1'b0, 0);
    check("r1_done", int'(done), 1);
    check("r1_busy_end", int'(busy), 0);
    tick();
    check("r1_done_single", int'(done), 0);
    check_results(-2, -2, -2);

    // Run 2: stalls, ignored start/cfg write during SEND_A, distinct results
    push_seq(NT);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("r2_ovf_cleared", int'(ovf_flag), 0);
    for (int c = 0; c < 100 && !sif.in_ready; c++) begin
      sif.out_ready = pat[c % 4];
      if (c == 3) begin
        start = 1'b1; cfg_wr_en = 1'b1; cfg_addr = 4'd0; cfg_data = 8'sd99;
      end
      tick();
      start = 1'b0; cfg_wr_en = 1'b0;
    end
    check("r2_in_ready", int'(sif.in_ready), 1);
    check("r2_queue_empty", exp_out.size(), 0);
    send_res(16'sd100, 1'b0, 1);
    send_res(-16'sd300, 1'b0, 2);
    send_res(16'sd7, 1'b0, 0);
    check("r2_done", int'(done), 1);
    check("r2_ovf", int'(ovf_flag), 0);
    tick();
    check_results(100, -300, 7);

    // Run 3: operands persist; reset during SEND_B
    push_seq(10);
    sif.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("r3_in_send_b", int'(sif.out_data), 0);
    sif.out_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("r3_rst_valid", int'(sif.out_valid), 0);
    check("r3_rst_busy", int'(busy), 0);
    check("r3_rst_in_ready", int'(sif.in_ready), 0);
    check("r3_rst_out_data", int'(sif.out_data), 0);
    res_addr = 2'd1; #1 check("r3_rst_res", int'(res_data), 0);
    check("r3_queue_empty", exp_out.size(), 0);

`ifdef MVM_DRV_TIMEOUT_EN
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    check("to_busy_before", int'(busy), 1);
    check("to_err_before", int'(err), 0);
    tick();
    check("to_err", int'(err), 1);
    check("to_busy", int'(busy), 0);
    check("to_done", int'(done), 0);
    tick();
`endif

    tick();
    check("done_pulses", done_cnt, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
